// File: rtl/wdb_agent_if.sv
// Handshake, SRAM and drain-side bundle between the WDB agent and its neighbours.
// master = upstream/arbiter/SRAM side, slave = the agent.
interface wdb_agent_if #(parameter int IDX_W = 4);
    logic             alloc_vld;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_rdy;
    logic             us_wr_vld;
    logic [IDX_W-1:0] us_wr_idx;
    logic             us_wr_rdy;
    logic             dataram_wr_vld;
    logic [IDX_W-1:0] dataram_wr_idx;
    logic             dataram_wr_rdy;
    logic             WDB_rdy;
    logic             wdb_mem_en;
    logic             wdb_wr_en;
    logic [IDX_W-1:0] wdb_addr;
    logic             ram_wr_vld;
    logic [IDX_W-1:0] ram_wr_idx;
    logic             wr_done;
    logic [IDX_W-1:0] wr_done_idx;
    logic             err;
    logic [IDX_W:0]   perf_busy_cnt;

    modport master (
        input  alloc_vld, alloc_idx, us_wr_rdy, dataram_wr_rdy, wdb_mem_en, wdb_wr_en,
               wdb_addr, ram_wr_vld, ram_wr_idx, wr_done, wr_done_idx, err, perf_busy_cnt,
        output alloc_rdy, us_wr_vld, us_wr_idx, dataram_wr_vld, dataram_wr_idx, WDB_rdy
    );
    modport slave (
        output alloc_vld, alloc_idx, us_wr_rdy, dataram_wr_rdy, wdb_mem_en, wdb_wr_en,
               wdb_addr, ram_wr_vld, ram_wr_idx, wr_done, wr_done_idx, err, perf_busy_cnt,
        input  alloc_rdy, us_wr_vld, us_wr_idx, dataram_wr_vld, dataram_wr_idx, WDB_rdy
    );
endinterface

// File: rtl/wdb_agent.sv
// Write-data-buffer agent: entry allocation, WDB SRAM write/read arbitration, fixed-latency drain.
// Optional busy-entry counter enabled by defining VC_WDB_PERF_CNT_EN.
module wdb_entry (
    input  logic clk,
    input  logic rst_n,
    input  logic set_alloc,
    input  logic set_fill,
    input  logic set_drain,
    input  logic set_free,
    output logic is_free,
    output logic is_alloc,
    output logic is_filled
);
    typedef enum logic [1:0] {FREE = 2'd0, ALLOC = 2'd1, FILLED = 2'd2, DRAIN = 2'd3} st_t;
    st_t st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= FREE;
        end else begin
            case (st)
                FREE:    if (set_alloc) st <= ALLOC;
                ALLOC:   if (set_fill)  st <= FILLED;
                FILLED:  if (set_drain) st <= DRAIN;
                DRAIN:   if (set_free)  st <= FREE;
                default: st <= FREE;
            endcase
        end
    end

    assign is_free   = (st == FREE);
    assign is_alloc  = (st == ALLOC);
    assign is_filled = (st == FILLED);
endmodule

module wdb_agent #(
    parameter int ENTRY_NUM     = 16,
    parameter int IDX_W         = $clog2(ENTRY_NUM),
    parameter int RD_WDB_DELAY  = 2,
    parameter int WR_DONE_DELAY = 4
) (
    input logic        clk,
    input logic        rst_n,
    wdb_agent_if.slave bus
);
    logic [ENTRY_NUM-1:0] free_v, alloc_v, filled_v;
    logic [ENTRY_NUM-1:0] set_alloc, set_fill, set_drain, set_free;
    logic                 alloc_any;
    logic [IDX_W-1:0]     alloc_idx_c;
    logic                 alloc_hs, wr_hs, dr_hs, wr_ok, dr_ok;
    logic                 err_q;

    logic [WR_DONE_DELAY-1:0]            vld_pipe;
    logic [WR_DONE_DELAY-1:0][IDX_W-1:0] idx_pipe;

    always_comb begin
        alloc_any   = 1'b0;
        alloc_idx_c = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (free_v[i]) begin
                alloc_any   = 1'b1;
                alloc_idx_c = IDX_W'(i);
            end
        end
    end

    // Upstream writes own the single SRAM port; a drain only goes when no write is pending.
    assign alloc_hs = alloc_any && bus.alloc_rdy;
    assign wr_hs    = bus.us_wr_vld && bus.WDB_rdy;
    assign dr_hs    = bus.dataram_wr_vld && bus.WDB_rdy && !bus.us_wr_vld;
    assign wr_ok    = wr_hs && alloc_v[bus.us_wr_idx];
    assign dr_ok    = dr_hs && filled_v[bus.dataram_wr_idx];

    assign bus.alloc_vld      = alloc_any;
    assign bus.alloc_idx      = alloc_idx_c;
    assign bus.us_wr_rdy      = bus.WDB_rdy;
    assign bus.dataram_wr_rdy = bus.WDB_rdy && !bus.us_wr_vld;
    assign bus.wdb_mem_en     = wr_ok || dr_ok;
    assign bus.wdb_wr_en      = wr_ok;
    assign bus.wdb_addr       = wr_hs ? bus.us_wr_idx : bus.dataram_wr_idx;

    genvar e;
    generate
        for (e = 0; e < ENTRY_NUM; e++) begin : g_entry
            assign set_alloc[e] = alloc_hs && (alloc_idx_c == IDX_W'(e));
            assign set_fill[e]  = wr_ok && (bus.us_wr_idx == IDX_W'(e));
            assign set_drain[e] = dr_ok && (bus.dataram_wr_idx == IDX_W'(e));
            assign set_free[e]  = vld_pipe[WR_DONE_DELAY-1] &&
                                  (idx_pipe[WR_DONE_DELAY-1] == IDX_W'(e));
            wdb_entry u_entry (
                .clk       (clk),
                .rst_n     (rst_n),
                .set_alloc (set_alloc[e]),
                .set_fill  (set_fill[e]),
                .set_drain (set_drain[e]),
                .set_free  (set_free[e]),
                .is_free   (free_v[e]),
                .is_alloc  (alloc_v[e]),
                .is_filled (filled_v[e])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[WR_DONE_DELAY-2:0], dr_ok};
            idx_pipe <= {idx_pipe[WR_DONE_DELAY-2:0], bus.dataram_wr_idx};
        end
    end

    assign bus.ram_wr_vld  = vld_pipe[RD_WDB_DELAY-1];
    assign bus.ram_wr_idx  = idx_pipe[RD_WDB_DELAY-1];
    assign bus.wr_done     = vld_pipe[WR_DONE_DELAY-1];
    assign bus.wr_done_idx = idx_pipe[WR_DONE_DELAY-1];

    // Illegal handshakes are swallowed without touching entry state; err is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((wr_hs && !alloc_v[bus.us_wr_idx]) ||
                     (dr_hs && !filled_v[bus.dataram_wr_idx])) begin
            err_q <= 1'b1;
        end
    end
    assign bus.err = err_q;

`ifdef VC_WDB_PERF_CNT_EN
    logic [IDX_W:0] busy_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (alloc_hs && !bus.wr_done) begin
            if (busy_q != (IDX_W+1)'(ENTRY_NUM)) busy_q <= busy_q + 1'b1;
        end else if (!alloc_hs && bus.wr_done) begin
            if (busy_q != '0) busy_q <= busy_q - 1'b1;
        end
    end
    assign bus.perf_busy_cnt = busy_q;
`else
    assign bus.perf_busy_cnt = '0;
`endif
endmodule
